// File: rtl/life_engine.sv
// Conway B3/S23 engine over a 15x20 tile grid, one row per cycle with a two-row history window.
// Build option: define LIFE_TORUS_EN for toroidal wrap; undefined treats off-grid cells as dead.
module life_engine #(
    parameter int FRAMES_PER_GEN = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        run,
    input  logic        step,
    input  logic        load_en,
    input  logic [3:0]  load_row,
    input  logic [19:0] load_data,
    input  logic [3:0]  rd_row,
    output logic [19:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] gen_count
);

    localparam int ROWS = 15;
    localparam int COLS = 20;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PREP = 2'd1;
    localparam logic [1:0] S_CALC = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam logic [7:0] FPG_LAST = 8'(FRAMES_PER_GEN - 1);
`ifdef LIFE_TORUS_EN
    localparam logic TORUS = 1'b1;
`else
    localparam logic TORUS = 1'b0;
`endif

    // Pads a row with its left/right neighbours: bit 0 is left of column 0, bit 21 right of column 19.
    function automatic logic [21:0] extend(input logic [19:0] x);
        return {x[0] & TORUS, x, x[19] & TORUS};
    endfunction

    function automatic logic [19:0] life_row(input logic [19:0] above, input logic [19:0] cur,
                                             input logic [19:0] below);
        logic [21:0] ae, ce, be;
        logic [3:0]  n;
        logic [19:0] nxt;
        ae  = extend(above);
        ce  = extend(cur);
        be  = extend(below);
        nxt = '0;
        for (int c = 0; c < COLS; c++) begin
            n = {3'b0, ae[c]} + {3'b0, ae[c+1]} + {3'b0, ae[c+2]}
              + {3'b0, ce[c]} + {3'b0, ce[c+2]}
              + {3'b0, be[c]} + {3'b0, be[c+1]} + {3'b0, be[c+2]};
            nxt[c] = (n == 4'd3) || (cur[c] && n == 4'd2);
        end
        return nxt;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [3:0]  r_q, r_d;
    logic [7:0]  fcnt_q, fcnt_d;
    logic [15:0] gen_q, gen_d;
    logic [19:0] prev_q, prev_d;
    logic [19:0] first_q, first_d;
    logic [19:0] grid_q [ROWS];
    logic [19:0] grid_d [ROWS];

    logic        frame_trig, start;
    logic [19:0] cur_row, below_row;

    assign frame_trig = run && frame_tick && (fcnt_q == FPG_LAST);
    assign start      = step || frame_trig;
    assign cur_row    = (r_q < 4'd15) ? grid_q[r_q] : '0;
    assign below_row  = (r_q < 4'd14) ? grid_q[r_q + 4'd1] : (TORUS ? first_q : '0);

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        fcnt_d  = fcnt_q;
        gen_d   = gen_q;
        prev_d  = prev_q;
        first_d = first_q;
        grid_d  = grid_q;

        if (run && frame_tick) begin
            fcnt_d = frame_trig ? 8'd0 : fcnt_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (load_en && load_row < 4'd15) begin
                    grid_d[load_row] = load_data;
                end
                if (start) begin
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                prev_d  = TORUS ? grid_q[ROWS-1] : '0;
                first_d = grid_q[0];
                r_d     = 4'd0;
                state_d = S_CALC;
            end
            S_CALC: begin
                // prev keeps the pre-update copy of the row just overwritten.
                grid_d[r_q] = life_row(prev_q, cur_row, below_row);
                prev_d      = cur_row;
                if (r_q == 4'd14) begin
                    state_d = S_DONE;
                end else begin
                    r_d = r_q + 4'd1;
                end
            end
            default: begin
                gen_d   = gen_q + 16'd1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            r_q     <= 4'd0;
            fcnt_q  <= 8'd0;
            gen_q   <= 16'd0;
            prev_q  <= '0;
            first_q <= '0;
            for (int i = 0; i < ROWS; i++) begin
                grid_q[i] <= '0;
            end
            grid_q[0] <= 20'h00002;
            grid_q[1] <= 20'h00004;
            grid_q[2] <= 20'h00007;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            fcnt_q  <= fcnt_d;
            gen_q   <= gen_d;
            prev_q  <= prev_d;
            first_q <= first_d;
            for (int i = 0; i < ROWS; i++) begin
                grid_q[i] <= grid_d[i];
            end
        end
    end

    assign rd_data   = (rd_row < 4'd15) ? grid_q[rd_row] : '0;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign gen_count = gen_q;

endmodule

// File: tb/tb_life_engine.sv
// Bench for life_engine: cell-wise reference model feeding a scoreboard of expected grids.
module tb_life_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        load_en = 1'b0;
    logic [3:0]  load_row = 4'd0;
    logic [19:0] load_data = 20'd0;
    logic [3:0]  rd_row = 4'd0;
    logic [19:0] rd_data;
    logic        busy;
    logic        done;
    logic [15:0] gen_count;

    life_engine #(.FRAMES_PER_GEN(8)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .run(run), .step(step),
        .load_en(load_en), .load_row(load_row), .load_data(load_data),
        .rd_row(rd_row), .rd_data(rd_data), .busy(busy), .done(done), .gen_count(gen_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [299:0] rows;
        logic [15:0]  gen;
    } exp_t;

    typedef struct {
        logic [3:0]  row;
        logic [19:0] exp;
    } rd_vec_t;

    typedef struct {
        logic [3:0]  lrow;
        logic [19:0] ldata;
        logic [3:0]  rrow;
        logic [19:0] exp;
    } ld_vec_t;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [19:0] mg [15];
    logic [15:0] mgen;
    exp_t        sbq [$];
    rd_vec_t     rv [6];
    ld_vec_t     lv [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int r = 0; r < 15; r++) mg[r] = '0;
        mg[0] = 20'h00002;
        mg[1] = 20'h00004;
        mg[2] = 20'h00007;
        mgen  = 16'd0;
    endfunction

    function automatic void model_step();
        logic [19:0] nx [15];
        int n, rr, cc;
        for (int r = 0; r < 15; r++) begin
            for (int c = 0; c < 20; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0) begin
                            rr = r + dr;
                            cc = c + dc;
`ifdef LIFE_TORUS_EN
                            rr = (rr + 15) % 15;
                            cc = (cc + 20) % 20;
`endif
                            if (rr >= 0 && rr < 15 && cc >= 0 && cc < 20)
                                n += int'(mg[rr][cc]);
                        end
                    end
                end
                nx[r][c] = (n == 3) || (n == 2 && mg[r][c]);
            end
        end
        for (int r = 0; r < 15; r++) mg[r] = nx[r];
        mgen = mgen + 16'd1;
    endfunction

    function automatic logic [299:0] pack_model();
        logic [299:0] p;
        for (int r = 0; r < 15; r++) p[r*20 +: 20] = mg[r];
        return p;
    endfunction

    task automatic push_exp();
        exp_t e;
        model_step();
        e.rows = pack_model();
        e.gen  = mgen;
        sbq.push_back(e);
    endtask

    task automatic check_rows(input string tag, input logic [299:0] rows);
        for (int r = 0; r < 15; r++) begin
            rd_row = 4'(r);
            #1;
            chk($sformatf("%s_row%0d", tag, r), 32'(rd_data), 32'(rows[r*20 +: 20]));
        end
        rd_row = 4'd15;
        #1;
        chk($sformatf("%s_row15", tag), 32'(rd_data), 32'd0);
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_sb: got empty queue expected an entry", tag);
        end else begin
            e = sbq.pop_front();
            chk($sformatf("%s_gen", tag), 32'(gen_count), 32'(e.gen));
            check_rows(tag, e.rows);
        end
    endtask

    // Counts negedges after the trigger until done; -1 if it never arrives.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            step    = 1'b0;
            load_en = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_step(input string tag);
        int lat;
        @(negedge clk);
        step = 1'b1;
        push_exp();
        wait_done(lat);
        chk({tag, "_lat"}, 32'(lat), 32'd17);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        sb_check(tag);
    endtask

    task automatic do_load(input logic [3:0] row, input logic [19:0] data);
        @(negedge clk);
        load_en   = 1'b1;
        load_row  = row;
        load_data = data;
        if (row < 4'd15) mg[row] = data;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        sbq.delete();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, ndone;
        logic [19:0] corner;

        rv[0] = '{4'd0, 20'h00002};
        rv[1] = '{4'd1, 20'h00004};
        rv[2] = '{4'd2, 20'h00007};
        rv[3] = '{4'd3, 20'h00000};
        rv[4] = '{4'd14, 20'h00000};
        rv[5] = '{4'd15, 20'h00000};
        lv[0] = '{4'd3, 20'hABCDE, 4'd3, 20'hABCDE};
        lv[1] = '{4'd14, 20'h80001, 4'd14, 20'h80001};
        lv[2] = '{4'd15, 20'hFFFFF, 4'd15, 20'h00000};
        lv[3] = '{4'd0, 20'h00000, 4'd0, 20'h00000};

        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_gen", 32'(gen_count), 32'd0);
        foreach (rv[i]) begin
            rd_row = rv[i].row;
            #1;
            chk($sformatf("rst_glider_rd%0d", rv[i].row), 32'(rd_data), 32'(rv[i].exp));
        end

        // Four generations move the glider one cell down-right.
        for (int k = 0; k < 4; k++) run_step($sformatf("glider%0d", k));
        rd_row = 4'd1; #1; chk("glider_row1", 32'(rd_data), 32'h00004);
        rd_row = 4'd2; #1; chk("glider_row2", 32'(rd_data), 32'h00008);
        rd_row = 4'd3; #1; chk("glider_row3", 32'(rd_data), 32'h0000E);
        chk("glider_gen4", 32'(gen_count), 32'd4);

        do_reset();
        foreach (lv[i]) begin
            do_load(lv[i].lrow, lv[i].ldata);
            rd_row = lv[i].rrow;
            #1;
            chk($sformatf("load_vec%0d", i), 32'(rd_data), 32'(lv[i].exp));
        end

        // Horizontal blinker turns vertical.
        do_reset();
        for (int r = 0; r < 15; r++) do_load(4'(r), 20'h0);
        do_load(4'd5, 20'h00070);
        run_step("blinker");
        rd_row = 4'd4; #1; chk("blinker_row4", 32'(rd_data), 32'h00020);
        rd_row = 4'd5; #1; chk("blinker_row5", 32'(rd_data), 32'h00020);
        rd_row = 4'd6; #1; chk("blinker_row6", 32'(rd_data), 32'h00020);
        chk("blinker_gen", 32'(gen_count), 32'd1);

        // Step and load while busy must be dropped.
        @(negedge clk);
        step = 1'b1;
        push_exp();
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            step    = 1'b0;
            load_en = 1'b0;
            if (i == 5) begin
                chk("busy_mid", 32'(busy), 32'd1);
                step      = 1'b1;
                load_en   = 1'b1;
                load_row  = 4'd0;
                load_data = 20'hFFFFF;
            end
            if (done) begin
                lat = i;
                break;
            end
        end
        chk("busy_lat", 32'(lat), 32'd17);
        @(negedge clk);
        sb_check("busy_drop");
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("busy_no_extra_done", 32'(ndone), 32'd0);
        chk("busy_gen", 32'(gen_count), 32'd2);

        // Load and trigger in the same cycle.
        do_reset();
        @(negedge clk);
        load_en   = 1'b1;
        load_row  = 4'd14;
        load_data = 20'h00380;
        step      = 1'b1;
        mg[14]    = 20'h00380;
        push_exp();
        wait_done(lat);
        chk("ldstep_lat", 32'(lat), 32'd17);
        @(negedge clk);
        sb_check("ldstep");

        // Four corner cells: a wrapped block, or isolated cells that die.
        do_reset();
        for (int r = 0; r < 15; r++) do_load(4'(r), 20'h0);
        do_load(4'd0, 20'h80001);
        do_load(4'd14, 20'h80001);
        run_step("corner");
`ifdef LIFE_TORUS_EN
        corner = 20'h80001;
`else
        corner = 20'h00000;
`endif
        rd_row = 4'd0;  #1; chk("corner_row0", 32'(rd_data), 32'(corner));
        rd_row = 4'd14; #1; chk("corner_row14", 32'(rd_data), 32'(corner));

        // Automatic stepping every 8th frame tick.
        do_reset();
        run   = 1'b1;
        ndone = 0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            frame_tick = 1'b1;
            if (k % 8 == 0) push_exp();
            lat = -1;
            for (int c = 1; c <= 20; c++) begin
                @(negedge clk);
                frame_tick = 1'b0;
                if (done) begin
                    ndone++;
                    lat = c;
                end
            end
            if (k % 8 == 0) begin
                chk($sformatf("frame_lat_tick%0d", k), 32'(lat), 32'd17);
                sb_check($sformatf("frame%0d", k));
            end
        end
        chk("frame_done_count", 32'(ndone), 32'd3);
        run = 1'b0;

        // Reset while computing row 7 aborts the generation.
        do_reset();
        do_load(4'd7, 20'h00070);
        @(negedge clk);
        step = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            step = 1'b0;
        end
        chk("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy_after", 32'(busy), 32'd0);
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        chk("abort_gen", 32'(gen_count), 32'd0);
        model_reset();
        check_rows("abort_grid", pack_model());

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
